// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction port, data port and mem_system-side signals of mem_arbiter.
// The arbiter binds to the slave modport; the processor/memory side uses master.
interface mem_arbiter_if;
    logic [15:0] i_Addr;
    logic        i_Rd;
    logic [15:0] i_DataOut;
    logic        i_Done;
    logic        i_Stall;

    logic [15:0] d_Addr;
    logic [15:0] d_DataIn;
    logic        d_Rd;
    logic        d_Wr;
    logic [15:0] d_DataOut;
    logic        d_Done;
    logic        d_Stall;

    logic [15:0] m_Addr;
    logic [15:0] m_DataIn;
    logic        m_Rd;
    logic        m_Wr;
    logic [15:0] m_DataOut;
    logic        m_Done;
    logic        m_Stall;
    logic        m_CacheHit;
    logic        m_err;

    logic        hit;
    logic        err;

    modport slave (
        input  i_Addr, i_Rd, d_Addr, d_DataIn, d_Rd, d_Wr,
               m_DataOut, m_Done, m_Stall, m_CacheHit, m_err,
        output i_DataOut, i_Done, i_Stall, d_DataOut, d_Done, d_Stall,
               m_Addr, m_DataIn, m_Rd, m_Wr, hit, err
    );

    modport master (
        output i_Addr, i_Rd, d_Addr, d_DataIn, d_Rd, d_Wr,
               m_DataOut, m_Done, m_Stall, m_CacheHit, m_err,
        input  i_DataOut, i_Done, i_Stall, d_DataOut, d_Done, d_Stall,
               m_Addr, m_DataIn, m_Rd, m_Wr, hit, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter serialising accesses onto one mem_system, one transaction at a time.
// Optional MEM_ARB_ROUND_ROBIN_EN: last-grant register replaces D_PRIORITY on simultaneous requests.
module mem_arbiter #(
    parameter int unsigned TIMEOUT    = 64,
    parameter bit          D_PRIORITY = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state;
    grant_t        grant;
    logic [CW-1:0] cnt;
    logic          i_req;
    logic          d_req;
    logic          pick_d;
    logic          active;
    logic          i_done;
    logic          d_done;
    logic          timed_out;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic          last_d;
`endif

    assign i_req  = bus.i_Rd;
    assign d_req  = bus.d_Rd | bus.d_Wr;
    assign active = (state == ISSUE) || (state == WAIT);

    // A tie is the only case where the policy matters; otherwise the sole requester wins.
    always_comb begin
        pick_d = d_req;
        if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick_d = ~last_d;
`else
            pick_d = D_PRIORITY;
`endif
        end
    end

    assign timed_out = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    assign i_done = bus.m_Done & active & (grant == GNT_I);
    assign d_done = bus.m_Done & active & (grant == GNT_D);

    assign bus.i_Done    = i_done;
    assign bus.d_Done    = d_done;
    assign bus.i_DataOut = (grant == GNT_I) ? bus.m_DataOut : '0;
    assign bus.d_DataOut = (grant == GNT_D) ? bus.m_DataOut : '0;
    assign bus.i_Stall   = ~rst & i_req & ~i_done;
    assign bus.d_Stall   = ~rst & d_req & ~d_done;
    assign bus.hit       = bus.m_CacheHit & bus.m_Done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= GNT_NONE;
            cnt          <= '0;
            bus.m_Rd     <= 1'b0;
            bus.m_Wr     <= 1'b0;
            bus.m_Addr   <= '0;
            bus.m_DataIn <= '0;
            bus.err      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d       <= 1'b0;
`endif
        end else begin
            bus.m_Rd <= 1'b0;
            bus.m_Wr <= 1'b0;
            if (bus.m_err) begin
                bus.err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.d_Rd && bus.d_Wr) begin
                        bus.err <= 1'b1;
                    end
                    // The registered strobes double as the latched op for the ISSUE cycle.
                    if (i_req || d_req) begin
                        state <= ISSUE;
                        cnt   <= '0;
                        if (pick_d) begin
                            grant        <= GNT_D;
                            bus.m_Addr   <= bus.d_Addr;
                            bus.m_DataIn <= bus.d_DataIn;
                            bus.m_Rd     <= ~bus.d_Wr;
                            bus.m_Wr     <= bus.d_Wr;
                        end else begin
                            grant        <= GNT_I;
                            bus.m_Addr   <= bus.i_Addr;
                            bus.m_DataIn <= '0;
                            bus.m_Rd     <= 1'b1;
                        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_d <= pick_d;
`endif
                    end
                end

                ISSUE: begin
                    cnt <= '0;
                    if (bus.m_Done) begin
                        state <= IDLE;
                        grant <= GNT_NONE;
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (bus.m_Done) begin
                        state <= IDLE;
                        grant <= GNT_NONE;
                    end else if (timed_out) begin
                        state   <= IDLE;
                        grant   <= GNT_NONE;
                        bus.err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    grant <= GNT_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle plus literal spot checks.
module tb_mem_arbiter;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(TO), .D_PRIORITY(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: one outstanding transaction, its owner, and its age in cycles since the issue cycle.
    bit          mbusy;
    bit          mown_d;
    int          mage;
    logic [15:0] maddr;
    logic [15:0] mdata;
    bit          mwr;
    bit          merr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    bit          mlast_d;
`endif

    int lat;      // responder latency after issue; large = never completes
    bit stray;    // force an m_Done with no transaction outstanding

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mbusy = 0; mown_d = 0; mage = 0; maddr = '0; mdata = '0; mwr = 0; merr = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        mlast_d = 0;
`endif
    endtask

    task automatic model_update();
        bit dw;
        if (rst) begin
            model_reset();
        end else begin
            if (bus.m_err) merr = 1;
            if (!mbusy) begin
                if (bus.d_Rd && bus.d_Wr) merr = 1;
                if (bus.i_Rd || bus.d_Rd || bus.d_Wr) begin
                    if (bus.i_Rd && (bus.d_Rd || bus.d_Wr)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        dw = !mlast_d;
`else
                        dw = 1;
`endif
                    end else begin
                        dw = bus.d_Rd || bus.d_Wr;
                    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    mlast_d = dw;
`endif
                    mbusy = 1; mage = 0; mown_d = dw;
                    if (dw) begin
                        maddr = bus.d_Addr; mdata = bus.d_DataIn; mwr = bus.d_Wr;
                    end else begin
                        maddr = bus.i_Addr; mdata = '0; mwr = 0;
                    end
                end
            end else if (bus.m_Done) begin
                mbusy = 0;
            end else if (mage == int'(TO)) begin
                merr  = 1;
                mbusy = 0;
            end else begin
                mage++;
            end
        end
    endtask

    task automatic compare();
        bit e_id, e_dd;
        e_id = mbusy && !mown_d && bus.m_Done;
        e_dd = mbusy &&  mown_d && bus.m_Done;
        chk("m_Rd", bus.m_Rd, mbusy && mage == 0 && !mwr);
        chk("m_Wr", bus.m_Wr, mbusy && mage == 0 && mwr);
        if (mbusy) begin
            chk("m_Addr", bus.m_Addr, maddr);
            chk("m_DataIn", bus.m_DataIn, mdata);
        end
        chk("i_Done", bus.i_Done, e_id);
        chk("d_Done", bus.d_Done, e_dd);
        chk("i_DataOut", bus.i_DataOut, (mbusy && !mown_d) ? bus.m_DataOut : 16'h0);
        chk("d_DataOut", bus.d_DataOut, (mbusy &&  mown_d) ? bus.m_DataOut : 16'h0);
        chk("i_Stall", bus.i_Stall, !rst && bus.i_Rd && !e_id);
        chk("d_Stall", bus.d_Stall, !rst && (bus.d_Rd || bus.d_Wr) && !e_dd);
        chk("hit", bus.hit, bus.m_CacheHit && bus.m_Done);
        chk("err", bus.err, merr);
    endtask

    task automatic sample();
        @(negedge clk);
        bus.m_Done     = stray || (mbusy && mage == lat);
        bus.m_CacheHit = bus.m_Done && (lat == 0 || stray);
        bus.m_Stall    = mbusy && !bus.m_Done;
        bus.m_DataOut  = maddr ^ 16'h5A5A;
        #4;
        compare();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc();
        sample();
        tick();
    endtask

    task automatic do_reset();
        bus.i_Rd = 0; bus.d_Rd = 0; bus.d_Wr = 0; bus.m_err = 0;
        rst = 1;
        model_reset();
        cyc();
        cyc();
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_wr, done_at, stall_cyc, first_d, second_d, dones, got;
        int dq[$];

        bus.i_Addr = '0; bus.i_Rd = 0;
        bus.d_Addr = '0; bus.d_DataIn = '0; bus.d_Rd = 0; bus.d_Wr = 0;
        bus.m_DataOut = '0; bus.m_Done = 0; bus.m_Stall = 0; bus.m_CacheHit = 0; bus.m_err = 0;
        lat = 1000; stray = 0;
        rst = 1;
        model_reset();
        cyc();
        sample();
        chk("rst_m_addr", bus.m_Addr, 16'h0);
        chk("rst_m_datain", bus.m_DataIn, 16'h0);
        chk("rst_err", bus.err, 0);
        tick();
        rst = 0;
        cyc();

        // Fetch hit: request, then issue with Done in the same cycle.
        bus.i_Addr = 16'h0010; bus.i_Rd = 1; lat = 0;
        cyc();
        sample();
        chk("t1_m_rd", bus.m_Rd, 1);
        chk("t1_m_addr", bus.m_Addr, 16'h0010);
        chk("t1_i_done", bus.i_Done, 1);
        chk("t1_i_data", bus.i_DataOut, 16'h5A4A);
        chk("t1_hit", bus.hit, 1);
        tick();
        bus.i_Rd = 0;
        sample();
        chk("t1_m_rd_once", bus.m_Rd, 0);
        tick();

        // Data write miss with Done five cycles after issue.
        bus.d_Addr = 16'h0200; bus.d_DataIn = 16'hBEEF; bus.d_Wr = 1; lat = 5;
        n_wr = 0; done_at = -1; stall_cyc = 0;
        for (int c = 0; c < 20 && done_at < 0; c++) begin
            sample();
            if (c == 1) chk("t2_datain", bus.m_DataIn, 16'hBEEF);
            if (bus.m_Wr) n_wr++;
            if (bus.m_Rd) n_wr += 100;
            if (bus.d_Done) done_at = c;
            else if (bus.d_Stall) stall_cyc++;
            tick();
            if (done_at >= 0) bus.d_Wr = 0;
        end
        chk("t2_wr_pulses", n_wr, 1);
        chk("t2_done_cycle", done_at, 6);
        chk("t2_stall_cycles", stall_cyc, 6);
        cyc();

        // Simultaneous reads: D wins, I served next.
        bus.i_Addr = 16'h0030; bus.i_Rd = 1;
        bus.d_Addr = 16'h0400; bus.d_Rd = 1; lat = 2;
        first_d = -1; second_d = -1;
        for (int c = 0; c < 30 && second_d < 0; c++) begin
            bit sd, si;
            sample();
            sd = bus.d_Done; si = bus.i_Done;
            if (c == 1) begin
                chk("t3_first_addr", bus.m_Addr, 16'h0400);
                chk("t3_i_stall", bus.i_Stall, 1);
            end
            if (sd || si) begin
                if (first_d < 0) first_d = sd ? 1 : 0;
                else second_d = sd ? 1 : 0;
            end
            tick();
            if (sd) bus.d_Rd = 0;
            if (si) bus.i_Rd = 0;
        end
        chk("t3_first_is_d", first_d, 1);
        chk("t3_second_is_i", second_d, 0);
        bus.i_Rd = 0; bus.d_Rd = 0;
        cyc();

        // Timeout: no Done ever; eight WAIT cycles then err and back to IDLE.
        bus.d_Addr = 16'h0600; bus.d_Rd = 1; lat = 1000; dones = 0;
        for (int c = 0; c <= 10; c++) begin
            sample();
            if (bus.d_Done) dones++;
            if (c == 9)  chk("t4_err_before", bus.err, 0);
            if (c == 10) chk("t4_err_after", bus.err, 1);
            tick();
            if (c == 9) bus.d_Rd = 0;
        end
        chk("t4_no_done", dones, 0);
        bus.i_Addr = 16'h0070; bus.i_Rd = 1; lat = 1; got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            sample();
            if (bus.i_Done) got = c;
            tick();
        end
        bus.i_Rd = 0;
        chk("t4_next_done_cycle", got, 2);
        sample();
        chk("t4_err_sticky", bus.err, 1);
        tick();

        // Read+write together: err and performed as a write.
        do_reset();
        bus.d_Addr = 16'h0800; bus.d_DataIn = 16'h1234; bus.d_Rd = 1; bus.d_Wr = 1; lat = 1;
        sample();
        chk("t5_err_pre", bus.err, 0);
        tick();
        sample();
        chk("t5_m_wr", bus.m_Wr, 1);
        chk("t5_m_rd", bus.m_Rd, 0);
        chk("t5_err", bus.err, 1);
        tick();
        cyc();
        bus.d_Rd = 0; bus.d_Wr = 0;
        cyc();

        // m_err pulse is sticky until reset.
        do_reset();
        bus.m_err = 1;
        cyc();
        bus.m_err = 0;
        repeat (3) cyc();
        sample();
        chk("t6_err_sticky", bus.err, 1);
        tick();
        do_reset();
        sample();
        chk("t6_err_cleared", bus.err, 0);
        tick();

        // Reset during WAIT aborts with no Done afterwards.
        bus.d_Addr = 16'h0A00; bus.d_Rd = 1; lat = 1000;
        repeat (3) cyc();
        rst = 1;
        model_reset();
        sample();
        chk("t7_m_rd", bus.m_Rd, 0);
        chk("t7_m_addr", bus.m_Addr, 16'h0);
        chk("t7_d_stall", bus.d_Stall, 0);
        chk("t7_d_done", bus.d_Done, 0);
        tick();
        bus.d_Rd = 0;
        rst = 0;
        stray = 1;
        sample();
        chk("t7_stray_d_done", bus.d_Done, 0);
        chk("t7_stray_i_done", bus.i_Done, 0);
        tick();
        stray = 0;
        repeat (2) cyc();

        // Back-to-back fetch hits complete every second cycle.
        lat = 0; bus.i_Addr = 16'h0100; bus.i_Rd = 1;
        for (int c = 0; c < 7; c++) begin
            bit si;
            sample();
            si = bus.i_Done;
            if (si) dq.push_back(c);
            tick();
            if (si) bus.i_Addr = bus.i_Addr + 16'h2;
        end
        bus.i_Rd = 0;
        chk("t8_done_count", dq.size(), 3);
        if (dq.size() == 3) begin
            chk("t8_done0", dq[0], 1);
            chk("t8_done1", dq[1], 3);
            chk("t8_done2", dq[2], 5);
        end
        cyc();

        // Requester drops mid-grant: transaction still completes with Done.
        bus.d_Addr = 16'h0C00; bus.d_Rd = 1; lat = 3;
        cyc();
        cyc();
        bus.d_Rd = 0;
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            sample();
            if (bus.d_Done) dones++;
            tick();
        end
        chk("t9_dropped_done", dones, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
